// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronize, debounce and edge-detect two coin lines, queue coins, emit spaced pulses.
// Define COIN_ACCEPTOR_TALLY_EN to add the credit_total / tally_clr running tally.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          nickel_raw,
    input  logic                          dime_raw,
    input  logic                          accept_en,
    output logic                          nickel_in,
    output logic                          dime_in,
    output logic                          reject_coin,
`ifdef COIN_ACCEPTOR_TALLY_EN
    input  logic                          tally_clr,
    output logic [7:0]                    credit_total,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    // Channel index 0 is the nickel sensor, index 1 the dime sensor.
    logic [1:0]       raw_vec;
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d, deb_dly_q, deb_dly_d, evt_q, evt_d;
    logic [1:0][7:0]  cnt_q, cnt_d;

    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  reject_q, reject_d;

    logic   one_evt, jam, full, empty, push, pop, head;
    state_t state_q;
    logic   nickel_q, dime_q;

    assign raw_vec = {dime_raw, nickel_raw};

    always_comb begin
        sync1_d   = raw_vec;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        deb_dly_d = deb_q;
        evt_d     = deb_q & ~deb_dly_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] == deb_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == DEB_LAST) begin
                deb_d[ch] = ~deb_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 8'd1;
            end
        end
    end

    // A coin that cannot be pushed, or a simultaneous pair, goes to the return chute.
    assign one_evt = evt_q[0] ^ evt_q[1];
    assign jam     = evt_q[0] & evt_q[1];
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = one_evt & accept_en & ~full;
    assign pop     = (state_q == IDLE) & ~empty & accept_en;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = evt_q[1];
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        reject_d = jam | (one_evt & ~push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            deb_q     <= 2'b11;
            deb_dly_q <= 2'b11;
            evt_q     <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            reject_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            evt_q     <= evt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            reject_q  <= reject_d;
        end
    end

    // Each popped coin becomes one high cycle followed by a forced low cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            nickel_q <= 1'b0;
            dime_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q  <= PULSE;
                        nickel_q <= ~head;
                        dime_q   <= head;
                    end
                end
                PULSE: begin
                    state_q  <= GAP;
                    nickel_q <= 1'b0;
                    dime_q   <= 1'b0;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    nickel_q <= 1'b0;
                    dime_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] credit_q, credit_d;
    logic [8:0] credit_sum;

    always_comb begin
        credit_sum = {1'b0, credit_q} + (nickel_q ? 9'd5 : (dime_q ? 9'd10 : 9'd0));
        credit_d   = credit_sum[8] ? 8'hFF : credit_sum[7:0];
        if (tally_clr) begin
            credit_d = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_q <= 8'd0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_total = credit_q;
`endif

    assign nickel_in   = nickel_q;
    assign dime_in     = dime_q;
    assign reject_coin = reject_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: per-cycle stimulus tables run against a queue-based reference model.
module tb_coin_acceptor;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int LEN   = 512;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       nickelRaw = 1'b0;
    logic       dimeRaw = 1'b0;
    logic       acceptEn = 1'b0;
    logic       nickelIn, dimeIn, rejectCoin;
    logic [2:0] fifoCount;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic       tallyClr = 1'b0;
    logic [7:0] creditTotal;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .nickel_raw  (nickelRaw),
        .dime_raw    (dimeRaw),
        .accept_en   (acceptEn),
        .nickel_in   (nickelIn),
        .dime_in     (dimeIn),
        .reject_coin (rejectCoin),
`ifdef COIN_ACCEPTOR_TALLY_EN
        .tally_clr   (tallyClr),
        .credit_total(creditTotal),
`endif
        .fifo_count  (fifoCount)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    bit tabN [LEN];
    bit tabD [LEN];
    bit tabA [LEN];
    bit tabR [LEN];

    // Reference model: sensor pipelines as plain integers, the coin buffer as a queue.
    int mS1 [2];
    int mS2 [2];
    int mDeb [2];
    int mDly [2];
    int mRun [2];
    int mEv [2];
    int mQ [$];
    int mPhase, mN, mD, mRej, mCredit;

    int seenN, seenD, seenRej, maxCount, firstNCycle;

    function automatic void modelReset();
        for (int ch = 0; ch < 2; ch++) begin
            mS1[ch] = 0; mS2[ch] = 0; mRun[ch] = 0; mEv[ch] = 0;
            mDeb[ch] = 1; mDly[ch] = 1;
        end
        mQ.delete();
        mPhase = 0; mN = 0; mD = 0; mRej = 0; mCredit = 0;
    endfunction

    function automatic void modelStep(input bit nr, input bit dr, input bit acc);
        int raw [2];
        int oS1 [2];
        int oS2 [2];
        int oDeb [2];
        int oDly [2];
        int oEv [2];
        int oldSize;
        int coin;
        raw[0] = nr;
        raw[1] = dr;
        for (int ch = 0; ch < 2; ch++) begin
            oS1[ch] = mS1[ch]; oS2[ch] = mS2[ch]; oDeb[ch] = mDeb[ch];
            oDly[ch] = mDly[ch]; oEv[ch] = mEv[ch];
        end
        for (int ch = 0; ch < 2; ch++) begin
            mS1[ch] = raw[ch];
            mS2[ch] = oS1[ch];
            if (oS2[ch] == oDeb[ch]) begin
                mRun[ch] = 0;
            end else begin
                mRun[ch] = mRun[ch] + 1;
                if (mRun[ch] == DEB) begin
                    mDeb[ch] = 1 - oDeb[ch];
                    mRun[ch] = 0;
                end
            end
            mDly[ch] = oDeb[ch];
            mEv[ch]  = (oDeb[ch] == 1 && oDly[ch] == 0) ? 1 : 0;
        end
        mCredit = mCredit + 5 * mN + 10 * mD;
        if (mCredit > 255) mCredit = 255;
        oldSize = mQ.size();
        mRej = 0;
        if (mPhase == 1) begin
            mN = 0; mD = 0; mPhase = 2;
        end else if (mPhase == 2) begin
            mPhase = 0;
        end else if (oldSize > 0 && acc) begin
            coin = mQ.pop_front();
            mN = (coin == 0) ? 1 : 0;
            mD = (coin == 1) ? 1 : 0;
            mPhase = 1;
        end
        if (oEv[0] == 1 && oEv[1] == 1) begin
            mRej = 1;
        end else if (oEv[0] == 1 || oEv[1] == 1) begin
            if (acc && oldSize < DEPTH) mQ.push_back(oEv[1]);
            else mRej = 1;
        end
    endfunction

    task automatic cmpVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d required %0d", tag, got, want);
        end
    endtask

    task automatic checkOutput(input int cyc);
        cmpVal($sformatf("nickel_in@%0d", cyc), {31'b0, nickelIn}, mN);
        cmpVal($sformatf("dime_in@%0d", cyc), {31'b0, dimeIn}, mD);
        cmpVal($sformatf("reject_coin@%0d", cyc), {31'b0, rejectCoin}, mRej);
        cmpVal($sformatf("fifo_count@%0d", cyc), {29'b0, fifoCount}, mQ.size());
`ifdef COIN_ACCEPTOR_TALLY_EN
        cmpVal($sformatf("credit_total@%0d", cyc), {24'b0, creditTotal}, mCredit);
`endif
        if (nickelIn === 1'b1) begin
            if (seenN == 0) firstNCycle = cyc;
            seenN++;
        end
        if (dimeIn === 1'b1) seenD++;
        if (rejectCoin === 1'b1) seenRej++;
        if (int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
    endtask

    task automatic clearTallies();
        seenN = 0; seenD = 0; seenRej = 0; maxCount = 0; firstNCycle = -1;
    endtask

    task automatic clearTable(input bit acc);
        for (int c = 0; c < LEN; c++) begin
            tabN[c] = 1'b0; tabD[c] = 1'b0; tabA[c] = acc; tabR[c] = 1'b1;
        end
        clearTallies();
    endtask

    // Raw level held so that the coin's push/reject decision lands on edge pushEdge.
    task automatic addCoin(input bit isDime, input int pushEdge);
        for (int c = pushEdge - (DEB + 3); c < pushEdge; c++) begin
            if (isDime) tabD[c] = 1'b1;
            else tabN[c] = 1'b1;
        end
    endtask

    task automatic setAcc(input int from, input int upto, input bit v);
        for (int c = from; c <= upto; c++) tabA[c] = v;
    endtask

    // Entered and left on a falling clock edge; table entry c is sampled by rising edge c.
    task automatic applyStimulus(input int from, input int upto);
        for (int c = from; c <= upto; c++) begin
            nickelRaw = tabN[c];
            dimeRaw   = tabD[c];
            acceptEn  = tabA[c];
            if (tabR[c] == 1'b0 && reset == 1'b1) begin
                reset = 1'b0;
                #1;
                modelReset();
                cmpVal("async_reset_nickel", {31'b0, nickelIn}, 0);
                cmpVal("async_reset_dime", {31'b0, dimeIn}, 0);
                cmpVal("async_reset_reject", {31'b0, rejectCoin}, 0);
                cmpVal("async_reset_count", {29'b0, fifoCount}, 0);
            end else if (tabR[c] == 1'b1) begin
                reset = 1'b1;
            end
            @(posedge clock);
            if (reset == 1'b0) modelReset();
            else modelStep(tabN[c], tabD[c], tabA[c]);
            @(negedge clock);
            checkOutput(c);
        end
    endtask

    initial begin
        int lvl, hold, c;
        $display("[TB] coin_acceptor bench start");
        modelReset();
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clearTallies();
        checkOutput(-1);
        cmpVal("reset_count", {29'b0, fifoCount}, 0);

        // Release and let both sensors arm.
        clearTable(1'b1);
        applyStimulus(0, 9);

        // Single nickel held high 12 cycles from table cycle 2.
        clearTable(1'b1);
        for (int i = 2; i < 14; i++) tabN[i] = 1'b1;
        applyStimulus(0, 29);
        cmpVal("single_nickel_pulses", seenN, 1);
        cmpVal("single_nickel_dimes", seenD, 0);
        cmpVal("single_nickel_latency", firstNCycle, 2 + 4 + DEB);
        cmpVal("single_nickel_count", {29'b0, fifoCount}, 0);

        // Bouncing dime: toggles for 6 cycles then holds high.
        clearTable(1'b1);
        for (int i = 2; i < 8; i++) tabD[i] = ((i - 2) % 2 == 0);
        for (int i = 8; i < 18; i++) tabD[i] = 1'b1;
        applyStimulus(0, 29);
        cmpVal("bounce_dime_pulses", seenD, 1);
        cmpVal("bounce_nickel_pulses", seenN, 0);

        // Backpressure: every coin rejected while accept_en is low.
        clearTable(1'b0);
        for (int i = 0; i < 5; i++) addCoin(1'b1, 10 + 16 * i);
        applyStimulus(0, 89);
        cmpVal("backpressure_rejects", seenRej, 5);
        cmpVal("backpressure_pulses", seenN + seenD, 0);
        cmpVal("backpressure_max_count", maxCount, 0);

        // Fill the buffer to 4 using the busy PULSE/GAP window, then overflow with a 5th coin.
        clearTable(1'b0);
        addCoin(1'b0, 20);
        addCoin(1'b0, 40); addCoin(1'b1, 41);
        addCoin(1'b0, 60); addCoin(1'b1, 61);
        addCoin(1'b0, 80); addCoin(1'b1, 81);
        addCoin(1'b0, 100);
        setAcc(20, 20, 1'b1);
        setAcc(40, 42, 1'b1);
        setAcc(60, 62, 1'b1);
        setAcc(80, 82, 1'b1);
        setAcc(100, 129, 1'b1);
        applyStimulus(0, 129);
        cmpVal("fill_max_count", maxCount, DEPTH);
        cmpVal("fill_full_rejects", seenRej, 1);
        cmpVal("fill_nickel_pulses", seenN, 4);
        cmpVal("fill_dime_pulses", seenD, 3);
        cmpVal("fill_final_count", {29'b0, fifoCount}, 0);

        // Jam: both sensors rise together.
        clearTable(1'b1);
        addCoin(1'b0, 15);
        addCoin(1'b1, 15);
        applyStimulus(0, 29);
        cmpVal("jam_rejects", seenRej, 1);
        cmpVal("jam_pulses", seenN + seenD, 0);
        cmpVal("jam_max_count", maxCount, 0);

        // Reset during a pulse with two coins still queued and the nickel sensor stuck high.
        clearTable(1'b0);
        addCoin(1'b0, 20);
        addCoin(1'b0, 40); addCoin(1'b1, 41);
        addCoin(1'b0, 60); addCoin(1'b1, 61);
        setAcc(20, 20, 1'b1);
        setAcc(40, 42, 1'b1);
        setAcc(60, 62, 1'b1);
        setAcc(80, 129, 1'b1);
        for (int i = 75; i < 130; i++) tabN[i] = 1'b1;
        for (int i = 81; i < 84; i++) tabR[i] = 1'b0;
        applyStimulus(0, 80);
        cmpVal("midreset_pre_dime", seenD, 1);
        cmpVal("midreset_pre_count", {29'b0, fifoCount}, 2);
        clearTallies();
        applyStimulus(81, 129);
        cmpVal("midreset_post_pulses", seenN + seenD, 0);
        cmpVal("midreset_post_rejects", seenRej, 0);
        cmpVal("midreset_post_count", {29'b0, fifoCount}, 0);

        // Randomized sensor levels and acceptance windows.
        clearTable(1'b0);
        c = 0;
        lvl = 0;
        while (c < 400) begin
            hold = $urandom_range(1, 14);
            for (int i = 0; i < hold && c + i < 400; i++) tabN[c + i] = lvl[0];
            c += hold;
            lvl = 1 - lvl;
        end
        c = 0;
        lvl = 0;
        while (c < 400) begin
            hold = $urandom_range(1, 14);
            for (int i = 0; i < hold && c + i < 400; i++) tabD[c + i] = lvl[0];
            c += hold;
            lvl = 1 - lvl;
        end
        c = 0;
        while (c < 400) begin
            hold = $urandom_range(1, 20);
            lvl = $urandom_range(0, 3);
            for (int i = 0; i < hold && c + i < 400; i++) tabA[c + i] = (lvl != 0);
            c += hold;
        end
        applyStimulus(0, 399);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
